dmem_arbiter: RTL and testbench
===============================

// Module: dmem_arbiter
// PURPOSE
//  Shares the single-port data memory between N_REQ requesters, e.g. port 0 = pipeline MEM stage, port 1 = loader/debug.
//  Round-robin arbitration; one access in flight at a time.
//  Drives the memory's mem_read/mem_write/address/write_data.
//  Memory reads on negedge and writes on posedge; responses return registered.
// PARAMETERS
//  N_REQ   2    number of requesters (2..4)
//  DEPTH   256  memory depth in 32-bit words; the memory is word-indexed
// PORTS
//  clk             in   1         system clock
//  reset_n         in   1         synchronous, active-low reset
//  req_valid       in   N_REQ     per-requester access request
//  req_we          in   N_REQ     1 = store, 0 = load
//  req_addr        in   32*N_REQ  byte address, packed; requester i uses [32*i+:32]
//  req_wdata       in   32*N_REQ  store data, packed
//  req_ready       out  N_REQ     request accepted this cycle (one-hot or zero)
//  rsp_valid       out  N_REQ     one-cycle response strobe to the accepted requester
//  rsp_rdata       out  32        load data; 0 for stores and errors
//  rsp_err         out  1         misaligned or out-of-range access; qualified by rsp_valid
//  mem_read        out  1         memory read strobe
//  mem_write       out  1         memory write strobe
//  mem_address     out  32        word index: req_addr>>2, zero-extended
//  mem_write_data  out  32        store data to memory
//  mem_read_data   in   32        memory read data; valid after negedge of the mem_read cycle
// BEHAVIOUR
//  FSM states: IDLE -> ACCESS -> RESP -> IDLE; fixed 3-cycle occupancy.
//  Reset (reset_n=0 at posedge):
//   - state=IDLE, rr_ptr=0.
//   - req_ready, rsp_valid, rsp_err, mem_read, mem_write = 0; rsp_rdata, mem_address, mem_write_data = 0.
//  IDLE:
//   - g = first i with req_valid[i], searching from rr_ptr upward, modulo N_REQ.
//   - req_ready[g]=1 combinationally in the same cycle; this is the accept cycle N.
//   - Latch g, we, addr, wdata; set rr_ptr=(g+1)%N_REQ; go to ACCESS.
//   - If no request is valid: remain in IDLE, rr_ptr unchanged.
//  ACCESS (cycle N+1):
//   - Registered strobes: exactly one of mem_read/mem_write high for exactly one cycle.
//   - mem_address and mem_write_data stable throughout the cycle.
//   - Error if addr[1:0]!=0 or addr[31:2]>=DEPTH: both strobes stay 0 and err is latched.
//   - mem_read_data is captured at the posedge that ends ACCESS.
//  RESP (cycle N+2):
//   - rsp_valid[g]=1 for one cycle.
//   - rsp_rdata = captured data for a good load, else 0; rsp_err as latched.
//   - Return to IDLE. A new accept is possible in cycle N+3 at the earliest.
//  Load latency: accept at N -> data at N+2. Throughput: one access per 3 cycles.
//  req_ready is never asserted outside IDLE.
//  Requester rules:
//   - Hold valid/we/addr/wdata stable until ready.
//   - Dropping valid before ready is legal; no access occurs.
//  Simultaneous requests are resolved by rr_ptr alone; no starvation, worst-case wait is (N_REQ-1) accesses.
//  A requester may present its next request during RESP; it is considered in the following IDLE cycle.
//  Reset mid-operation:
//   - Any transaction in ACCESS or RESP is abandoned with no rsp_valid.
//   - A mem_write already high at the resetting edge completes; nothing is retried.
//  Outputs with no active access hold 0 (strobes, rsp_*); mem_address and mem_write_data hold their last value.
// STRUCTURE
//  mips.h holds:
//   - `define DMEM_ST_IDLE/ACCESS/RESP 2-bit encodings
//   - `DMEM_DEPTH default 256
//   - `WORD_W 32
//  Sub-module rr_arbiter (N_REQ):
//   - Combinational: valid vector + rr_ptr -> one-hot grant and index.
//   - Reused by future bus arbiters.
//  Top level holds the FSM, latch registers and response registers.
// TESTING
//  1. Reset: hold reset_n=0 3 cycles with req_valid=2'b11 -> no ready/strobes, all outputs 0.
//  2. Port0 store 0xDEADBEEF @0x10 at N, then load @0x10.
//     -> mem_write in N+1, mem_address=4; load rsp_rdata=0xDEADBEEF at its N+2, rsp_err=0.
//  3. Both ports valid every cycle from reset -> grants alternate 0,1,0,1; accepts 3 cycles apart; each rsp_valid goes to its own port.
//  4. Port1 load @0x13 (misaligned), then @0x400 (DEPTH=256) -> no strobes; rsp_err=1, rsp_rdata=0 at N+2.
//  5. reset_n low during ACCESS of a port0 load -> no rsp_valid; FSM in IDLE; next request accepted on first cycle after reset.
//  6. Port0 drops valid before ready while FSM is busy -> no transaction; rr_ptr unchanged.

Source files
------------

// File: rtl/dmem_arbiter_pkg.sv
// Shared types and helpers for the data-memory arbiter.
// Covers the FSM encoding, the latched transaction flags and the address check.
package dmem_arbiter_pkg;

  localparam int unsigned WORD_W     = 32;
  localparam int unsigned DMEM_DEPTH = 256;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } dmem_state_e;

  typedef struct packed {
    logic we;
    logic err;
  } dmem_txn_t;

  // Misaligned byte address or word index beyond the memory depth.
  function automatic logic addr_bad(input logic [WORD_W-1:0] addr,
                                    input int unsigned       depth);
    return (addr[1:0] != 2'b00) || ({2'b00, addr[WORD_W-1:2]} >= depth);
  endfunction

endpackage

// File: rtl/dmem_arbiter_rr.sv
// Combinational round-robin picker: the first valid requester at or after i_ptr wins.
// Produces a one-hot grant plus its index; reusable by other bus arbiters.
module rr_arbiter #(
  parameter  int unsigned N_REQ = 2,
  localparam int unsigned PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic [N_REQ-1:0] i_valid,
  input  logic [PTR_W-1:0] i_ptr,
  output logic [N_REQ-1:0] o_grant_c,
  output logic [PTR_W-1:0] o_idx_c,
  output logic             o_any_c
);

  always_comb begin
    int unsigned j;
    j         = 0;
    o_grant_c = '0;
    o_idx_c   = '0;
    o_any_c   = 1'b0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      j = (32'(i_ptr) + k) % N_REQ;
      if (!o_any_c && i_valid[PTR_W'(j)]) begin
        o_any_c              = 1'b1;
        o_grant_c[PTR_W'(j)] = 1'b1;
        o_idx_c              = PTR_W'(j);
      end
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing one single-port data memory between N_REQ requesters.
// One access in flight: accept (IDLE) -> strobe (ACCESS) -> respond (RESP).
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int unsigned N_REQ = 2,
  parameter int unsigned DEPTH = DMEM_DEPTH
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic [N_REQ-1:0]          req_valid,
  input  logic [N_REQ-1:0]          req_we,
  input  logic [WORD_W*N_REQ-1:0]   req_addr,
  input  logic [WORD_W*N_REQ-1:0]   req_wdata,
  output logic [N_REQ-1:0]          req_ready,
  output logic [N_REQ-1:0]          rsp_valid,
  output logic [WORD_W-1:0]         rsp_rdata,
  output logic                      rsp_err,
  output logic                      mem_read,
  output logic                      mem_write,
  output logic [WORD_W-1:0]         mem_address,
  output logic [WORD_W-1:0]         mem_write_data,
  input  logic [WORD_W-1:0]         mem_read_data
);

  localparam int unsigned PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  dmem_state_e        r_state;
  logic [PTR_W-1:0]   r_ptr;
  logic [PTR_W-1:0]   r_gidx;
  dmem_txn_t          r_txn;

  logic [N_REQ-1:0]   w_grant;
  logic [PTR_W-1:0]   w_gidx;
  logic               w_any;
  logic               w_we;
  logic               w_bad;
  logic [WORD_W-1:0]  w_addr;
  logic [WORD_W-1:0]  w_wdata;
  logic [PTR_W-1:0]   w_ptr_next;

  rr_arbiter #(.N_REQ(N_REQ)) u_rr (
    .i_valid   (req_valid),
    .i_ptr     (r_ptr),
    .o_grant_c (w_grant),
    .o_idx_c   (w_gidx),
    .o_any_c   (w_any)
  );

  // Select the granted requester's payload.
  always_comb begin
    w_addr  = '0;
    w_wdata = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (w_grant[i]) begin
        w_addr  = req_addr[i*WORD_W +: WORD_W];
        w_wdata = req_wdata[i*WORD_W +: WORD_W];
      end
    end
  end

  assign w_we       = |(req_we & w_grant);
  assign w_bad      = addr_bad(w_addr, DEPTH);
  assign w_ptr_next = (w_gidx == PTR_W'(N_REQ - 1)) ? '0 : w_gidx + PTR_W'(1);

  // Ready is a same-cycle handshake; suppressed while reset is asserted.
  assign req_ready = (reset_n && r_state == ST_IDLE) ? w_grant : '0;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state        <= ST_IDLE;
      r_ptr          <= '0;
      r_gidx         <= '0;
      r_txn          <= '0;
      rsp_valid      <= '0;
      rsp_rdata      <= '0;
      rsp_err        <= 1'b0;
      mem_read       <= 1'b0;
      mem_write      <= 1'b0;
      mem_address    <= '0;
      mem_write_data <= '0;
    end else begin
      mem_read  <= 1'b0;
      mem_write <= 1'b0;
      rsp_valid <= '0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_any) begin
            r_gidx      <= w_gidx;
            r_txn.we    <= w_we;
            r_txn.err   <= w_bad;
            r_ptr       <= w_ptr_next;
            mem_address <= {2'b00, w_addr[WORD_W-1:2]};
            if (!w_bad) begin
              mem_read  <= !w_we;
              mem_write <= w_we;
              if (w_we) mem_write_data <= w_wdata;
            end
            r_state <= ST_ACCESS;
          end
        end
        ST_ACCESS: begin
          // Memory drove read data on the negedge of this cycle.
          rsp_valid <= {{(N_REQ-1){1'b0}}, 1'b1} << r_gidx;
          rsp_err   <= r_txn.err;
          rsp_rdata <= (!r_txn.we && !r_txn.err) ? mem_read_data : '0;
          r_state   <= ST_RESP;
        end
        ST_RESP: r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a behavioural word memory
// (read on negedge, write on posedge) preloaded with 0xA5000000 | index.
module tb_dmem_arbiter;

  logic        clk;
  logic        reset_n;
  logic [1:0]  req_valid;
  logic [1:0]  req_we;
  logic [63:0] req_addr;
  logic [63:0] req_wdata;
  logic [1:0]  req_ready;
  logic [1:0]  rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] mem_address;
  logic [31:0] mem_write_data;
  logic [31:0] mem_read_data;

  logic [31:0] mem [0:255];

  int n_checks = 0;
  int n_errors = 0;

  dmem_arbiter #(.N_REQ(2), .DEPTH(256)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .req_valid      (req_valid),
    .req_we         (req_we),
    .req_addr       (req_addr),
    .req_wdata      (req_wdata),
    .req_ready      (req_ready),
    .rsp_valid      (rsp_valid),
    .rsp_rdata      (rsp_rdata),
    .rsp_err        (rsp_err),
    .mem_read       (mem_read),
    .mem_write      (mem_write),
    .mem_address    (mem_address),
    .mem_write_data (mem_write_data),
    .mem_read_data  (mem_read_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) if (mem_read)  mem_read_data <= mem[mem_address[7:0]];
  always @(posedge clk) if (mem_write) mem[mem_address[7:0]] <= mem_write_data;

  typedef struct {
    logic        port;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  vec_t vecs [10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One isolated transaction, starting just after a posedge with the FSM idle.
  task automatic do_txn(input vec_t v, input int idx);
    logic [1:0] oh;
    string      tag;
    oh  = v.port ? 2'b10 : 2'b01;
    tag = $sformatf("vec%0d", idx);
    req_valid = oh;
    req_we    = v.we ? oh : 2'b00;
    if (v.port) begin
      req_addr[63:32]  = v.addr;
      req_wdata[63:32] = v.wdata;
    end else begin
      req_addr[31:0]   = v.addr;
      req_wdata[31:0]  = v.wdata;
    end
    @(negedge clk);
    chk({tag, "_ready"}, 32'(req_ready), 32'(oh));
    tick();
    req_valid = 2'b00;
    @(negedge clk);
    chk({tag, "_ready_busy"}, 32'(req_ready), 32'h0);
    chk({tag, "_mem_read"},  32'(mem_read),  32'(!v.we && !v.exp_err));
    chk({tag, "_mem_write"}, 32'(mem_write), 32'(v.we && !v.exp_err));
    if (!v.exp_err) chk({tag, "_mem_addr"}, mem_address, {2'b00, v.addr[31:2]});
    if (v.we && !v.exp_err) chk({tag, "_mem_wdata"}, mem_write_data, v.wdata);
    tick();
    @(negedge clk);
    chk({tag, "_rsp_valid"}, 32'(rsp_valid), 32'(oh));
    chk({tag, "_rsp_rdata"}, rsp_rdata, v.exp_rdata);
    chk({tag, "_rsp_err"},   32'(rsp_err), 32'(v.exp_err));
    tick();
  endtask

  initial begin
    logic [1:0] exp_rdy;
    logic [1:0] exp_rv;
    for (int i = 0; i < 256; i++) mem[i] = 32'hA500_0000 | 32'(i);

    vecs[0] = '{1'b0, 1'b1, 32'h10,  32'hDEADBEEF, 32'h0,        1'b0};
    vecs[1] = '{1'b0, 1'b0, 32'h10,  32'h0,        32'hDEADBEEF, 1'b0};
    vecs[2] = '{1'b1, 1'b0, 32'h13,  32'h0,        32'h0,        1'b1};
    vecs[3] = '{1'b1, 1'b0, 32'h400, 32'h0,        32'h0,        1'b1};
    vecs[4] = '{1'b1, 1'b1, 32'h3FC, 32'h12345678, 32'h0,        1'b0};
    vecs[5] = '{1'b0, 1'b0, 32'h3FC, 32'h0,        32'h12345678, 1'b0};
    vecs[6] = '{1'b0, 1'b1, 32'h13,  32'hCAFEF00D, 32'h0,        1'b1};
    vecs[7] = '{1'b1, 1'b0, 32'h10,  32'h0,        32'hDEADBEEF, 1'b0};
    vecs[8] = '{1'b1, 1'b0, 32'h20,  32'h0,        32'hA5000008, 1'b0};
    vecs[9] = '{1'b0, 1'b1, 32'h400, 32'h55555555, 32'h0,        1'b1};

    // Reset held three cycles with both requesters asking.
    reset_n   = 1'b0;
    req_valid = 2'b11;
    req_we    = 2'b00;
    req_addr  = {32'h4, 32'h0};
    req_wdata = '0;
    repeat (3) tick();
    @(negedge clk);
    chk("rst_ready",     32'(req_ready), 32'h0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'h0);
    chk("rst_rsp_err",   32'(rsp_err),   32'h0);
    chk("rst_mem_read",  32'(mem_read),  32'h0);
    chk("rst_mem_write", 32'(mem_write), 32'h0);
    chk("rst_rsp_rdata", rsp_rdata,      32'h0);
    chk("rst_mem_addr",  mem_address,    32'h0);
    chk("rst_mem_wdata", mem_write_data, 32'h0);
    tick();
    reset_n = 1'b1;

    // Both ports valid every cycle: grants alternate 0,1,0,1 every 3 cycles.
    for (int k = 0; k < 12; k++) begin
      exp_rdy = (k % 3 == 0) ? (((k / 3) % 2 == 0) ? 2'b01 : 2'b10) : 2'b00;
      exp_rv  = (k % 3 == 2) ? (((k / 3) % 2 == 0) ? 2'b01 : 2'b10) : 2'b00;
      @(negedge clk);
      chk($sformatf("rr_ready_c%0d", k), 32'(req_ready), 32'(exp_rdy));
      chk($sformatf("rr_rsp_valid_c%0d", k), 32'(rsp_valid), 32'(exp_rv));
      if (k % 3 == 2)
        chk($sformatf("rr_rdata_c%0d", k), rsp_rdata,
            ((k / 3) % 2 == 0) ? 32'hA5000000 : 32'hA5000001);
      tick();
    end
    req_valid = 2'b00;

    for (int i = 0; i < 10; i++) do_txn(vecs[i], i);

    // Reset during ACCESS of a port0 load abandons it; rr_ptr returns to 0.
    req_we    = 2'b00;
    req_addr  = {32'h4, 32'h8};
    req_valid = 2'b01;
    @(negedge clk);
    chk("mid_rst_ready", 32'(req_ready), 32'h1);
    tick();
    req_valid = 2'b00;
    reset_n   = 1'b0;
    @(negedge clk);
    chk("mid_rst_mem_read", 32'(mem_read), 32'h1);
    tick();
    reset_n   = 1'b1;
    req_valid = 2'b11;
    @(negedge clk);
    chk("mid_rst_no_rsp",   32'(rsp_valid), 32'h0);
    chk("post_rst_ready",   32'(req_ready), 32'h1);
    tick();
    req_valid = 2'b00;
    @(negedge clk);
    chk("post_rst_mem_read", 32'(mem_read), 32'h1);
    chk("post_rst_mem_addr", mem_address,   32'h2);
    tick();
    @(negedge clk);
    chk("post_rst_rsp_valid", 32'(rsp_valid), 32'h1);
    chk("post_rst_rdata",     rsp_rdata,       32'hA5000002);
    tick();

    // Port0 raises and drops a store while busy: no access, rr_ptr untouched.
    req_valid = 2'b10;
    @(negedge clk);
    chk("drop_p1_ready", 32'(req_ready), 32'h2);
    tick();
    req_valid = 2'b01;
    req_we    = 2'b01;
    req_addr  = {32'h4, 32'h10};
    req_wdata = {32'h0, 32'hBAD0BAD0};
    @(negedge clk);
    chk("drop_busy_ready", 32'(req_ready), 32'h0);
    tick();
    req_valid = 2'b00;
    @(negedge clk);
    chk("drop_p1_rsp",   32'(rsp_valid), 32'h2);
    chk("drop_p1_rdata", rsp_rdata,      32'hA5000001);
    tick();
    @(negedge clk);
    chk("drop_idle_ready", 32'(req_ready), 32'h0);
    tick();
    @(negedge clk);
    chk("drop_no_write", 32'(mem_write), 32'h0);
    chk("drop_no_read",  32'(mem_read),  32'h0);
    tick();
    req_we    = 2'b00;
    req_valid = 2'b11;
    @(negedge clk);
    chk("drop_ptr_ready", 32'(req_ready), 32'h1);
    tick();
    req_valid = 2'b00;
    tick();
    @(negedge clk);
    chk("drop_rsp_valid", 32'(rsp_valid), 32'h1);
    chk("drop_rdata",     rsp_rdata,      32'hDEADBEEF);
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
